cpu_fpu_div_issue: RTL and testbench

CPU_FPU_DIV_ISSUE -- requirements
Module: cpu_fpu_div_issue

---
 rtl/cpu_fpu_div_issue_if.sv | 34 +++
 rtl/cpu_fpu_div_issue.sv | 133 +++++++++++++
 tb/tb_cpu_fpu_div_issue.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_fpu_div_issue_if.sv
// Purpose: bundles the execute-stage command, divider and writeback signals of the FP divide issue block.
// Ports:   slave  = the issue block (cpu_fpu_div_issue); master = its surroundings (execute, divider, writeback).
//          Signal names keep the block's i_/o_ view so both ends read the same way.
interface cpu_fpu_div_issue_if #(
   parameter int TAG_WIDTH = 5
);
   // execute stage command
   logic                 i_valid;
   logic [31:0]          i_op1;
   logic [31:0]          i_op2;
   logic [TAG_WIDTH-1:0] i_tag;
   logic                 o_busy;
   // divider request / completion
   logic                 o_div_request;
   logic [31:0]          o_div_op1;
   logic [31:0]          o_div_op2;
   logic                 i_div_ready;
   logic [31:0]          i_div_result;
   // writeback
   logic                 o_valid;
   logic [31:0]          o_result;
   logic [TAG_WIDTH-1:0] o_tag;
   logic                 i_ack;

   modport slave (
      input  i_valid, i_op1, i_op2, i_tag, i_div_ready, i_div_result, i_ack,
      output o_busy, o_div_request, o_div_op1, o_div_op2, o_valid, o_result, o_tag
   );

   modport master (
      output i_valid, i_op1, i_op2, i_tag, i_div_ready, i_div_result, i_ack,
      input  o_busy, o_div_request, o_div_op1, o_div_op2, o_valid, o_result, o_tag
   );
endinterface

// File: rtl/cpu_fpu_div_issue.sv
// Purpose: issues one FP divide at a time to an external divider and holds the result for writeback.
// Latency: accept -> divider request next cycle; divider ready -> o_valid next cycle (cache hit: accept -> o_valid next cycle).
// Backpressure: o_busy stalls upstream outside IDLE; o_valid/o_result/o_tag held until i_ack.
// Ports: i_clock, i_reset (sync, active-low), bus (cpu_fpu_div_issue_if.slave).
// Option: define FPU_DIV_CACHE_EN to add a one-entry {op1, op2, result} cache that bypasses the divider on a repeat.
module cpu_fpu_div_issue #(
   parameter int TAG_WIDTH = 5
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   cpu_fpu_div_issue_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DONE  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t               state;
   logic [31:0]          op1_q;
   logic [31:0]          op2_q;
   logic [TAG_WIDTH-1:0] tag_q;
   logic [31:0]          result_q;
   logic                 valid_q;
   logic                 req_q;
   logic                 busy_q;

`ifdef FPU_DIV_CACHE_EN
   logic                 cache_vld;
   logic [31:0]          cache_op1;
   logic [31:0]          cache_op2;
   logic [31:0]          cache_res;
   logic                 cache_hit;

   assign cache_hit = cache_vld && (bus.i_op1 == cache_op1) && (bus.i_op2 == cache_op2);

   // Entry is refreshed from every divider capture, so it always reflects the last real divide.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         cache_vld <= 1'b0;
         cache_op1 <= '0;
         cache_op2 <= '0;
         cache_res <= '0;
      end else if (state == REQ && bus.i_div_ready) begin
         cache_vld <= 1'b1;
         cache_op1 <= op1_q;
         cache_op2 <= op2_q;
         cache_res <= bus.i_div_result;
      end
   end
`endif

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state    <= IDLE;
         op1_q    <= '0;
         op2_q    <= '0;
         tag_q    <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         req_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_valid) begin
                  op1_q  <= bus.i_op1;
                  op2_q  <= bus.i_op2;
                  tag_q  <= bus.i_tag;
                  busy_q <= 1'b1;
`ifdef FPU_DIV_CACHE_EN
                  if (cache_hit) begin
                     result_q <= cache_res;
                     valid_q  <= 1'b1;
                     state    <= DONE;
                  end else begin
                     req_q <= 1'b1;
                     state <= REQ;
                  end
`else
                  req_q <= 1'b1;
                  state <= REQ;
`endif
               end
            end
            REQ: begin
               if (bus.i_div_ready) begin
                  result_q <= bus.i_div_result;
                  req_q    <= 1'b0;
                  valid_q  <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (bus.i_ack) begin
                  valid_q <= 1'b0;
                  // A ready still high belongs to the finished op; wait it out so the
                  // next request is never raised against a stale ready.
                  if (bus.i_div_ready) begin
                     state <= DRAIN;
                  end else begin
                     busy_q <= 1'b0;
                     state  <= IDLE;
                  end
               end
            end
            DRAIN: begin
               if (!bus.i_div_ready) begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               valid_q <= 1'b0;
               req_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_busy        = busy_q;
   assign bus.o_div_request = req_q;
   assign bus.o_div_op1     = op1_q;
   assign bus.o_div_op2     = op2_q;
   assign bus.o_valid       = valid_q;
   assign bus.o_result      = result_q;
   assign bus.o_tag         = tag_q;

endmodule

// File: tb/tb_cpu_fpu_div_issue.sv
module tb_cpu_fpu_div_issue;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   cpu_fpu_div_issue_if #(.TAG_WIDTH(5)) bus ();

   cpu_fpu_div_issue #(.TAG_WIDTH(5)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_valid"}, 32'(bus.o_valid), 32'd0);
      check({name, "_req"},   32'(bus.o_div_request), 32'd0);
      check({name, "_busy"},  32'(bus.o_busy), 32'd0);
      check({name, "_res"},   bus.o_result, 32'd0);
      check({name, "_tag"},   32'(bus.o_tag), 32'd0);
      check({name, "_op1"},   bus.o_div_op1, 32'd0);
      check({name, "_op2"},   bus.o_div_op2, 32'd0);
   endtask

   task automatic present(input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
      bus.i_valid = 1'b1;
      bus.i_op1   = a;
      bus.i_op2   = b;
      bus.i_tag   = t;
   endtask

   initial begin
      vectors          = 0;
      miscompares      = 0;
      rst              = 1'b0;
      bus.i_valid      = 1'b0;
      bus.i_op1        = '0;
      bus.i_op2        = '0;
      bus.i_tag        = '0;
      bus.i_div_ready  = 1'b0;
      bus.i_div_result = '0;
      bus.i_ack        = 1'b0;

      // reset state, with a command presented during reset that must be discarded
      tick();
      present(32'h40C00000, 32'h40000000, 5'd1);
      tick();
      check_all_zero("reset");
      bus.i_valid = 1'b0;
      rst = 1'b1;
      tick();
      check("post_reset_busy", 32'(bus.o_busy), 32'd0);
      check("post_reset_req",  32'(bus.o_div_request), 32'd0);

      // 6.0 / 2.0, tag 3, ack held high
      present(32'h40C00000, 32'h40000000, 5'd3);
      bus.i_ack = 1'b1;
      tick();
      bus.i_valid = 1'b0;
      check("t1_req",   32'(bus.o_div_request), 32'd1);
      check("t1_busy",  32'(bus.o_busy), 32'd1);
      check("t1_op1",   bus.o_div_op1, 32'h40C00000);
      check("t1_op2",   bus.o_div_op2, 32'h40000000);
      check("t1_novld", 32'(bus.o_valid), 32'd0);
      tick();
      check("t1_req_hold", 32'(bus.o_div_request), 32'd1);
      bus.i_div_ready  = 1'b1;
      bus.i_div_result = 32'h40400000;
      tick();
      check("t1_valid", 32'(bus.o_valid), 32'd1);
      check("t1_res",   bus.o_result, 32'h40400000);
      check("t1_tag",   32'(bus.o_tag), 32'd3);
      check("t1_req_dn", 32'(bus.o_div_request), 32'd0);
      tick();
      // ready still high from the finished op: DRAIN, pulse over
      check("t1_pulse_end", 32'(bus.o_valid), 32'd0);
      check("t1_drain_busy", 32'(bus.o_busy), 32'd1);
      check("t1_drain_req",  32'(bus.o_div_request), 32'd0);
      bus.i_div_ready = 1'b0;
      tick();
      check("t1_idle_busy", 32'(bus.o_busy), 32'd0);

      // 1.0 / 0.0 -> +inf, ack held low for 10 cycles
      bus.i_ack = 1'b0;
      present(32'h3F800000, 32'h00000000, 5'd7);
      tick();
      bus.i_valid = 1'b0;
      check("t2_req", 32'(bus.o_div_request), 32'd1);
      bus.i_div_ready  = 1'b1;
      bus.i_div_result = 32'h7F800000;
      tick();
      bus.i_div_ready  = 1'b0;
      bus.i_div_result = 32'h12345678;
      for (int i = 0; i < 10; i++) begin
         check("t2_valid_hold", 32'(bus.o_valid), 32'd1);
         check("t2_res_hold",   bus.o_result, 32'h7F800000);
         check("t2_tag_hold",   32'(bus.o_tag), 32'd7);
         tick();
      end
      check("t2_req_low", 32'(bus.o_div_request), 32'd0);
      bus.i_ack = 1'b1;
      tick();
      bus.i_ack = 1'b0;
      check("t2_ack_valid", 32'(bus.o_valid), 32'd0);
      check("t2_ack_busy",  32'(bus.o_busy), 32'd0);

      // back-to-back: B held on the bus while A is in flight
      present(32'h40C00000, 32'h40400000, 5'd1);
      tick();
      present(32'h41200000, 32'h40A00000, 5'd2);
      tick();
      check("t3_ignored_op1", bus.o_div_op1, 32'h40C00000);
      check("t3_ignored_tag", 32'(bus.o_tag), 32'd1);
      bus.i_div_ready  = 1'b1;
      bus.i_div_result = 32'h40000000;
      bus.i_ack        = 1'b1;
      tick();
      check("t3_a_valid", 32'(bus.o_valid), 32'd1);
      check("t3_a_tag",   32'(bus.o_tag), 32'd1);
      tick();
      check("t3_drain_req", 32'(bus.o_div_request), 32'd0);
      check("t3_drain_vld", 32'(bus.o_valid), 32'd0);
      tick();
      check("t3_drain2_req",  32'(bus.o_div_request), 32'd0);
      check("t3_drain2_busy", 32'(bus.o_busy), 32'd1);
      bus.i_div_ready = 1'b0;
      tick();
      check("t3_idle_req",  32'(bus.o_div_request), 32'd0);
      check("t3_idle_busy", 32'(bus.o_busy), 32'd0);
      tick();
      bus.i_valid = 1'b0;
      check("t3_b_req", 32'(bus.o_div_request), 32'd1);
      check("t3_b_op1", bus.o_div_op1, 32'h41200000);
      check("t3_b_op2", bus.o_div_op2, 32'h40A00000);
      bus.i_div_ready  = 1'b1;
      bus.i_div_result = 32'h40000000;
      tick();
      check("t3_b_res", bus.o_result, 32'h40000000);
      check("t3_b_tag", 32'(bus.o_tag), 32'd2);
      bus.i_div_ready = 1'b0;
      tick();
      check("t3_b_done", 32'(bus.o_busy), 32'd0);
      bus.i_ack = 1'b0;

      // reset while in REQ abandons the op
      present(32'h41000000, 32'h40000000, 5'd5);
      tick();
      bus.i_valid = 1'b0;
      check("t4_req", 32'(bus.o_div_request), 32'd1);
      rst = 1'b0;
      tick();
      check_all_zero("t4_rst");
      rst = 1'b1;
      tick();
      check("t4_no_valid", 32'(bus.o_valid), 32'd0);
      present(32'h40C00000, 32'h40000000, 5'd4);
      tick();
      bus.i_valid = 1'b0;
      check("t4_next_req", 32'(bus.o_div_request), 32'd1);
      bus.i_div_ready  = 1'b1;
      bus.i_div_result = 32'h40400000;
      tick();
      check("t4_next_res", bus.o_result, 32'h40400000);
      check("t4_next_tag", 32'(bus.o_tag), 32'd4);
      bus.i_div_ready = 1'b0;
      bus.i_ack       = 1'b1;
      tick();
      bus.i_ack = 1'b0;
      check("t4_next_idle", 32'(bus.o_busy), 32'd0);

      // repeat 6.0 / 2.0
      present(32'h40C00000, 32'h40000000, 5'd9);
      tick();
      bus.i_valid = 1'b0;
`ifdef FPU_DIV_CACHE_EN
      check("t5_hit_valid", 32'(bus.o_valid), 32'd1);
      check("t5_hit_req",   32'(bus.o_div_request), 32'd0);
      check("t5_hit_res",   bus.o_result, 32'h40400000);
      check("t5_hit_tag",   32'(bus.o_tag), 32'd9);
      bus.i_ack = 1'b1;
      tick();
      bus.i_ack = 1'b0;
      check("t5_hit_req2", 32'(bus.o_div_request), 32'd0);
      check("t5_hit_idle", 32'(bus.o_busy), 32'd0);
      present(32'h40C00000, 32'h40400000, 5'd6);
      tick();
      bus.i_valid = 1'b0;
      check("t5_miss_req", 32'(bus.o_div_request), 32'd1);
      check("t5_miss_vld", 32'(bus.o_valid), 32'd0);
      bus.i_div_ready  = 1'b1;
      bus.i_div_result = 32'h40000000;
      tick();
      check("t5_miss_res", bus.o_result, 32'h40000000);
      check("t5_miss_tag", 32'(bus.o_tag), 32'd6);
`else
      check("t5_req",  32'(bus.o_div_request), 32'd1);
      check("t5_nvld", 32'(bus.o_valid), 32'd0);
      bus.i_div_ready  = 1'b1;
      bus.i_div_result = 32'h40400000;
      tick();
      check("t5_res", bus.o_result, 32'h40400000);
      check("t5_tag", 32'(bus.o_tag), 32'd9);
`endif
      bus.i_div_ready = 1'b0;
      bus.i_ack       = 1'b1;
      tick();
      bus.i_ack = 1'b0;
      check("t5_idle", 32'(bus.o_busy), 32'd0);

      // stray divider ready in IDLE is ignored
      bus.i_div_ready  = 1'b1;
      bus.i_div_result = 32'hDEADBEEF;
      tick();
      tick();
      check("t6_stray_vld",  32'(bus.o_valid), 32'd0);
      check("t6_stray_busy", 32'(bus.o_busy), 32'd0);
      bus.i_div_ready = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
